// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands and results.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             zero;
  logic             last;
  logic             accept;

  assign zero   = (i_divisor == '0);
  assign last   = (cnt == CW'(1));
  assign accept = (state == IDLE) && i_start;

  // Quotient bits shift into the dividend register as it empties.
  assign shifted = {prem, dvd[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign qbit    = ~diff[WIDTH];
  assign rem_n   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_fin   = {dvd[WIDTH-2:0], qbit};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg;
  logic r_neg;

  assign mag_a = i_dividend[WIDTH-1] ? WIDTH'(0) - i_dividend : i_dividend;
  assign mag_b = i_divisor[WIDTH-1] ? WIDTH'(0) - i_divisor : i_divisor;
  assign res_q = q_neg ? WIDTH'(0) - q_fin : q_fin;
  assign res_r = r_neg ? WIDTH'(0) - rem_n : rem_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept && !zero) begin
      q_neg <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
      r_neg <= i_dividend[WIDTH-1];
    end
  end
`else
  assign mag_a = i_dividend;
  assign mag_b = i_divisor;
  assign res_q = q_fin;
  assign res_r = rem_n;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (i_start) state_n = zero ? DONE : CALC;
      CALC:    if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt           <= '0;
      dvd           <= '0;
      dvs           <= '0;
      prem          <= '0;
      o_quo         <= '0;
      o_rem         <= '0;
      o_div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero) begin
        o_quo         <= '1;
        o_rem         <= i_dividend;
        o_div_by_zero <= 1'b1;
      end else begin
        dvd  <= mag_a;
        dvs  <= mag_b;
        prem <= '0;
        cnt  <= CW'(WIDTH);
      end
    end else if (state == CALC) begin
      prem <= rem_n;
      dvd  <= q_fin;
      cnt  <= cnt - CW'(1);
      if (last) begin
        o_quo         <= res_q;
        o_rem         <= res_r;
        o_div_by_zero <= 1'b0;
      end
    end
  end

  assign o_busy = (state == CALC);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table plus multi-cycle corner sequences.
// Build with SEQ_DIVIDER_SIGNED_EN defined to exercise the signed variant.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         dbz;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } vec_t;

  vec_t vecs[$];

  seq_divider #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_busy       (busy),
    .o_done       (done),
    .o_quo        (quo),
    .o_rem        (rem),
    .o_div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int a, int b, int q, int r, int dz, int cyc);
    vec_t v;
    v.a   = W'(a);
    v.b   = W'(b);
    v.q   = W'(q);
    v.r   = W'(r);
    v.dz  = dz[0];
    v.cyc = cyc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start is driven in cycle 0 and sampled on edge 0; cycle k is the
  // half-period before edge k, where done is sampled.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     output logic [W-1:0] q, output logic [W-1:0] r,
                     output logic dz, output int cyc);
    logic [W-1:0] pq;
    logic [W-1:0] pr;
    logic         pd;
    bit           stable;
    bit           busy_ok;
    @(negedge clk);
    chk("idle_no_done", done, 0);
    pq = quo;
    pr = rem;
    pd = dbz;
    stable = 1'b1;
    busy_ok = 1'b1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    cyc = 1;
    while (!done && cyc < 30) begin
      if (quo !== pq || rem !== pr || dbz !== pd) stable = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("hold_during_calc", stable, 1);
    chk("busy_during_calc", busy_ok, 1);
    chk("busy_at_done", busy, 0);
    q = quo;
    r = rem;
    dz = dbz;
  endtask

  initial begin
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
    int           pulses;
    int           dcyc;
    logic [W-1:0] dq;
    logic [W-1:0] dr;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back(mk(-7, 2, -3, -1, 0, 9));
    vecs.push_back(mk(7, -2, -3, 1, 0, 9));
    vecs.push_back(mk(-128, -1, -128, 0, 0, 9));
    vecs.push_back(mk(-5, 0, -1, -5, 1, 1));
    vecs.push_back(mk(-7, -2, 3, -1, 0, 9));
    vecs.push_back(mk(7, 3, 2, 1, 0, 9));
    vecs.push_back(mk(127, 1, 127, 0, 0, 9));
`else
    vecs.push_back(mk(7, 3, 2, 1, 0, 9));
    vecs.push_back(mk(10, 2, 5, 0, 0, 9));
    vecs.push_back(mk(19, 4, 4, 3, 0, 9));
    vecs.push_back(mk(200, 0, 255, 200, 1, 1));
    vecs.push_back(mk(255, 1, 255, 0, 0, 9));
    vecs.push_back(mk(0, 5, 0, 0, 0, 9));
    vecs.push_back(mk(5, 9, 0, 5, 0, 9));
    vecs.push_back(mk(255, 255, 1, 0, 0, 9));
    vecs.push_back(mk(128, 16, 8, 0, 0, 9));
    vecs.push_back(mk(0, 0, 255, 0, 1, 1));
    vecs.push_back(mk(254, 127, 2, 0, 0, 9));
`endif

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quo", quo, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i].a, vecs[i].b, q, r, dz, cyc);
      chk($sformatf("v%0d_cyc", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_quo", i), q, vecs[i].q);
      chk($sformatf("v%0d_rem", i), r, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), dz, vecs[i].dz);
    end

    // Second start while busy must be dropped.
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    dcyc = -1;
    dq = '0;
    dr = '0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        pulses++;
        if (dcyc < 0) begin
          dcyc = c;
          dq = quo;
          dr = rem;
        end
      end
      if (c == 4) begin
        chk("ign_busy", busy, 1);
        start = 1'b1;
        dividend = 8'd9;
        divisor = 8'd3;
      end
      if (c == 5) start = 1'b0;
      @(negedge clk);
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_cyc", dcyc, 9);
    chk("ign_quo", dq, 14);
    chk("ign_rem", dr, 2);
    chk("ign_dbz", dbz, 0);

    // Reset mid-division aborts without a done pulse.
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quo", quo, 0);
    chk("abort_rem", rem, 0);
    chk("abort_dbz", dbz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run(8'd50, 8'd6, q, r, dz, cyc);
    chk("post_rst_cyc", cyc, 9);
    chk("post_rst_quo", q, 8);
    chk("post_rst_rem", r, 2);
    chk("post_rst_dbz", dz, 0);

`ifndef SEQ_DIVIDER_SIGNED_EN
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = (i % 7 == 0) ? '0 : (i % 7 == 1) ? W'(1) : W'($urandom);
      run(a, b, q, r, dz, cyc);
      if (b == 0) begin
        chk("rnd_cyc", cyc, 1);
        chk("rnd_quo", q, 255);
        chk("rnd_rem", r, a);
        chk("rnd_dbz", dz, 1);
      end else begin
        chk("rnd_cyc", cyc, 9);
        chk("rnd_quo", q, a / b);
        chk("rnd_rem", r, a % b);
        chk("rnd_dbz", dz, 0);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider producing quotient and remainder with a start/done handshake.
- Sequential counterpart of the combinational `/` and `%` operators in the arithmetic chapter.
- Used where a single-cycle divider is too large or too slow.
- Restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32).

Ports:
- i_clk  input  1  system clock, all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request a division; sampled only in IDLE.
- i_dividend  input  WIDTH  dividend, captured on the accepted i_start edge.
- i_divisor  input  WIDTH  divisor, captured on the accepted i_start edge.
- o_busy  output  1  high while a division is in progress (CALC).
- o_done  output  1  single-cycle pulse: results valid.
- o_quo  output  WIDTH  quotient.
- o_rem  output  WIDTH  remainder.
- o_div_by_zero  output  1  flag for the last result: divisor was 0.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; o_busy=0, o_done=0, o_quo=0, o_rem=0, o_div_by_zero=0; internal counter/shift registers cleared. Reset mid-operation aborts the division; no o_done is produced for it.
- States: IDLE, CALC, DONE.
- IDLE, i_start=1, divisor!=0: capture operands, clear partial remainder (WIDTH+1 bits), counter=WIDTH; go to CALC; o_busy=1 from the next cycle.
- IDLE, i_start=1, divisor==0: go directly to DONE. o_quo={WIDTH{1'b1}}, o_rem=dividend, o_div_by_zero=1.
- CALC: each cycle, shift {rem,dividend} left 1 and trial-subtract the divisor. If non-negative, keep the difference and set quotient LSB=1; else restore and set it to 0. Decrement the counter. When the counter reaches 0, load o_quo/o_rem, clear o_div_by_zero, go to DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=0, return to IDLE.
- Latency: start edge at cycle 0. o_done is high in cycle WIDTH+1 (9 for WIDTH=8). For a zero divisor, o_done is high in cycle 1.
- o_quo, o_rem and o_div_by_zero hold their values after o_done until the next accepted result. They do not change during CALC.
- i_start while o_busy=1 or in DONE is ignored, with no queuing. Back-to-back: i_start may be asserted in the cycle after o_done.
- Operand changes after capture have no effect.
- X/Z on i_divisor at capture: no special handling; simulation propagates X.
- Results satisfy dividend = quo*divisor + rem, with rem < divisor (unsigned).

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands and results are two's complement; magnitudes are divided by the same unsigned core, adding 0 cycles.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case: most-negative / -1 gives quo=most-negative, rem=0, o_div_by_zero=0.
  - Divide by zero: quo=all ones (-1), rem=dividend.
- Undefined: purely unsigned behaviour as above; no sign logic synthesized.

Test Plan:
- 7/3: o_done in cycle 9 → quo=2, rem=1, dbz=0. Then 10/2 → 5, 0. Then 19/4 → 4, 3. Starts issued the cycle after each o_done.
- 200/0: o_done in cycle 1 → quo=255, rem=200, dbz=1. Then 255/1 → 255, 0, dbz=0.
- Start 100/7, pulse i_start with 9/3 at cycle 4 → single o_done in cycle 9 with quo=14, rem=2; the second request is ignored.
- Start 50/6, assert i_rst_n=0 at cycle 5 → all outputs 0 immediately, no o_done. After release, 50/6 → 8, 2.
- Randomized 1000 operand pairs including divisor 0 and 1, checked against the `/` and `%` operators. Outputs must stay stable between o_done pulses.
- With SEQ_DIVIDER_SIGNED_EN:
  - -7/2 → quo=-3, rem=-1.
  - 7/-2 → -3, 1.
  - -128/-1 → -128, 0.
  - -5/0 → -1, -5, dbz=1.
